// File: rtl/cmp_serial_pkg.sv
// rtl/cmp_serial_pkg.sv - shared types and sizing helpers for the serial comparator sequencer.
package cmp_serial_pkg;

  localparam int CMP_WIDTH_DEFAULT = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } cmp_state_e;

  // Index width never drops below one bit, even for the minimum two-bit operand.
  function automatic int idx_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// rtl/cmp_bit_cell.sv - single-bit XOR inequality cell shared across all bit positions.
module cmp_bit_cell (
  input  logic x,
  input  logic y,
  output logic ne
);

  assign ne = x ^ y;

endmodule

// File: rtl/cmp_serial_seq.sv
// rtl/cmp_serial_seq.sv - MSB-first serial inequality compare with early exit on the first differing bit.
// Optional magnitude output a_gt_b is enabled by defining CMP_SERIAL_MAG_EN.
module cmp_serial_seq
  import cmp_serial_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH_DEFAULT,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             diff,
`ifdef CMP_SERIAL_MAG_EN
  output logic [IDX_W-1:0] diff_idx,
  output logic             a_gt_b
`else
  output logic [IDX_W-1:0] diff_idx
`endif
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_SHIFT = ST_SHIFT;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             diff_q, diff_d;
  logic [IDX_W-1:0] idx_q, idx_d;
`ifdef CMP_SERIAL_MAG_EN
  logic             gt_q, gt_d;
`endif

  logic bit_a;
  logic bit_b;
  logic cell_ne;

  assign bit_a = a_q[cnt_q];
  assign bit_b = b_q[cnt_q];

  cmp_bit_cell u_cell (
    .x  (bit_a),
    .y  (bit_b),
    .ne (cell_ne)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    idx_d   = idx_q;
`ifdef CMP_SERIAL_MAG_EN
    gt_d    = gt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = IDX_W'(WIDTH - 1);
          diff_d  = 1'b0;
          idx_d   = '0;
`ifdef CMP_SERIAL_MAG_EN
          gt_d    = 1'b0;
`endif
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Mismatch wins over the last-bit check; the counter is never decremented past zero.
        if (cell_ne) begin
          diff_d  = 1'b1;
          idx_d   = cnt_q;
`ifdef CMP_SERIAL_MAG_EN
          gt_d    = bit_a;
`endif
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == '0) begin
          diff_d  = 1'b0;
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= 1'b0;
      idx_q   <= '0;
`ifdef CMP_SERIAL_MAG_EN
      gt_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      idx_q   <= idx_d;
`ifdef CMP_SERIAL_MAG_EN
      gt_q    <= gt_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign diff_idx = idx_q;
`ifdef CMP_SERIAL_MAG_EN
  assign a_gt_b   = gt_q;
`endif

endmodule

// File: tb/tb_cmp_serial_seq.sv
// tb/tb_cmp_serial_seq.sv - directed vector bench for the serial comparator sequencer.
module tb_cmp_serial_seq;

  localparam int W  = 6;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic          diff;
  logic [IW-1:0] diff_idx;
`ifdef CMP_SERIAL_MAG_EN
  logic          a_gt_b;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cmp_serial_seq #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
`ifdef CMP_SERIAL_MAG_EN
    .diff_idx (diff_idx),
    .a_gt_b   (a_gt_b)
`else
    .diff_idx (diff_idx)
`endif
  );

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    int            lat;
    logic          diff;
    logic [IW-1:0] idx;
    logic          gt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge just after the accept edge; counts edges until done is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat);
    chk({tag, "_lat"}, 32'(lat), 32'(v.lat));
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_diff"}, {31'd0, diff}, {31'd0, v.diff});
    chk({tag, "_idx"}, {29'd0, diff_idx}, {29'd0, v.idx});
`ifdef CMP_SERIAL_MAG_EN
    chk({tag, "_gt"}, {31'd0, a_gt_b}, {31'd0, v.gt});
`endif
  endtask

  initial begin
    int   lat;
    int   gap;
    vec_t v;

    vecs[0] = '{6'b001010, 6'b000101, 3, 1'b1, 3'd3, 1'b1};
    vecs[1] = '{6'b000010, 6'b000010, 6, 1'b0, 3'd0, 1'b0};
    vecs[2] = '{6'b010000, 6'b000001, 2, 1'b1, 3'd4, 1'b1};
    vecs[3] = '{6'b000000, 6'b000001, 6, 1'b1, 3'd0, 1'b0};
    vecs[4] = '{6'b100000, 6'b000000, 1, 1'b1, 3'd5, 1'b1};
    vecs[5] = '{6'b000000, 6'b100000, 1, 1'b1, 3'd5, 1'b0};
    vecs[6] = '{6'b111110, 6'b111111, 6, 1'b1, 3'd0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_diff", {31'd0, diff}, 32'd0);
    chk("reset_idx", {29'd0, diff_idx}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      a = vecs[i].a; b = vecs[i].b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      wait_done(lat);
      check_result($sformatf("v%0d", i), vecs[i], lat);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
      chk($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_hold_idx", i), {29'd0, diff_idx}, {29'd0, vecs[i].idx});
    end

    // Reset mid-SHIFT aborts the compare; diff is 1 from the last vector beforehand.
    a = 6'b100000; b = 6'b000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_done", {31'd0, done}, 32'd0);
      chk("rst_mid_diff", {31'd0, diff}, 32'd0);
      chk("rst_mid_idx", {29'd0, diff_idx}, 32'd0);
    end
    rst = 1'b0;
    gap = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) gap++;
    end
    chk("rst_no_done", 32'(gap), 32'd0);

    // Start pulse during SHIFT and operand changes after accept are both ignored.
    v = vecs[0];
    a = v.a; b = v.b; start = 1'b1;
    @(negedge clk);
    a = 6'b100000; b = 6'b000000;
    @(negedge clk);
    start = 1'b0; a = 6'b111111; b = 6'b000000;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_result("hs", v, lat);
    gap = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy || done) gap++;
    end
    chk("hs_not_queued", 32'(gap), 32'd0);
    chk("hs_hold_diff", {31'd0, diff}, 32'd1);

    // start held high across two operand sets.
    a = vecs[2].a; b = vecs[2].b; start = 1'b1;
    @(negedge clk);
    a = vecs[3].a; b = vecs[3].b;
    wait_done(lat);
    check_result("b2b_first", vecs[2], lat);
    @(negedge clk);
    chk("b2b_gap_busy", {31'd0, busy}, 32'd0);
    chk("b2b_gap_diff", {31'd0, diff}, 32'd1);
    chk("b2b_gap_idx", {29'd0, diff_idx}, 32'd4);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_restart", {31'd0, busy}, 32'd1);
    wait_done(lat);
    check_result("b2b_second", vecs[3], lat);
    @(negedge clk);
    chk("b2b_end", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
